// File: rtl/parking_pkg.sv
// Shared types and defaults for the car-park gate/occupancy logic.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY_OPEN,
        EXIT_OPEN,
        CLOSE
    } gate_state_t;

    localparam int unsigned PARK_CAPACITY    = 8;
    localparam int unsigned GATE_OPEN_CYCLES = 5;

    // Bits needed to hold 0..cap inclusive.
    function automatic int unsigned count_w(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor/actuator bundle between the occupancy controller and the lot.
// PARKING_DENY_STATS_EN adds stats_clr and deny_count.
interface parking_occupancy_ctrl_if #(
    parameter int unsigned COUNT_W = parking_pkg::count_w(parking_pkg::PARK_CAPACITY)
);
    logic               entry_req;
    logic               exit_req;
    logic               car_passed;
    logic               gate_open;
    logic [COUNT_W-1:0] count;
    logic               full_signal;
    logic               empty;
    logic               entry_denied;
`ifdef PARKING_DENY_STATS_EN
    logic               stats_clr;
    logic [7:0]         deny_count;

    modport master (
        input  entry_req, exit_req, car_passed, stats_clr,
        output gate_open, count, full_signal, empty, entry_denied, deny_count
    );
    modport slave (
        output entry_req, exit_req, car_passed, stats_clr,
        input  gate_open, count, full_signal, empty, entry_denied, deny_count
    );
`else
    modport master (
        input  entry_req, exit_req, car_passed,
        output gate_open, count, full_signal, empty, entry_denied
    );
    modport slave (
        output entry_req, exit_req, car_passed,
        input  gate_open, count, full_signal, empty, entry_denied
    );
`endif
endinterface

// File: rtl/parking_occupancy_ctrl_gate_timer.sv
// Gate-open timer: cleared by start, counts while run, flags the last allowed open cycle.
module gate_timer #(
    parameter int unsigned GATE_OPEN_CYCLES = parking_pkg::GATE_OPEN_CYCLES
) (
    input  logic clk_1Hz,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expired
);
    logic [3:0] timer_q, timer_d;

    assign expired = (timer_q == 4'(GATE_OPEN_CYCLES - 1));

    always_comb begin
        timer_d = timer_q;
        if (start) begin
            timer_d = 4'd0;
        end else if (run && !expired) begin
            timer_d = timer_q + 4'd1;
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (!reset) begin
            timer_q <= 4'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Single-gate entry/exit sequencer with occupancy count and full-indicator pulse.
// Optional PARKING_DENY_STATS_EN adds a saturating denied-entry counter.
module parking_occupancy_ctrl #(
    parameter int unsigned CAPACITY         = parking_pkg::PARK_CAPACITY,
    parameter int unsigned GATE_OPEN_CYCLES = parking_pkg::GATE_OPEN_CYCLES
) (
    input  logic                     clk_1Hz,
    input  logic                     reset,
    parking_occupancy_ctrl_if.master bus
);
    import parking_pkg::*;

    localparam int unsigned COUNT_W = count_w(CAPACITY);
    localparam logic [COUNT_W-1:0] CapCnt    = COUNT_W'(CAPACITY);
    localparam logic [COUNT_W-1:0] CapCntM1  = COUNT_W'(CAPACITY - 1);
    localparam logic [COUNT_W-1:0] OneCnt    = COUNT_W'(1);

    gate_state_t        state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               gate_q, gate_d;
    logic               full_q, full_d;
    logic               denied_q, denied_d;
    logic               empty_q, empty_d;
    logic               timer_start, timer_run, timer_expired;

    gate_timer #(
        .GATE_OPEN_CYCLES(GATE_OPEN_CYCLES)
    ) u_gate_timer (
        .clk_1Hz(clk_1Hz),
        .reset  (reset),
        .start  (timer_start),
        .run    (timer_run),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gate_d      = gate_q;
        full_d      = 1'b0;
        denied_d    = 1'b0;
        timer_start = 1'b0;
        timer_run   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.exit_req && (count_q != '0)) begin
                    state_d     = EXIT_OPEN;
                    gate_d      = 1'b1;
                    timer_start = 1'b1;
                end else if (bus.entry_req) begin
                    if (count_q < CapCnt) begin
                        state_d     = ENTRY_OPEN;
                        gate_d      = 1'b1;
                        timer_start = 1'b1;
                    end else if (!full_q) begin
                        // Gating on the previous pulse makes a held request alternate 1,0,1,0.
                        denied_d = 1'b1;
                        full_d   = 1'b1;
                    end
                end
            end
            ENTRY_OPEN: begin
                timer_run = 1'b1;
                if (bus.car_passed) begin
                    count_d = count_q + OneCnt;
                    full_d  = (count_q == CapCntM1);
                    gate_d  = 1'b0;
                    state_d = CLOSE;
                end else if (timer_expired) begin
                    gate_d  = 1'b0;
                    state_d = CLOSE;
                end
            end
            EXIT_OPEN: begin
                timer_run = 1'b1;
                if (bus.car_passed) begin
                    count_d = count_q - OneCnt;
                    gate_d  = 1'b0;
                    state_d = CLOSE;
                end else if (timer_expired) begin
                    gate_d  = 1'b0;
                    state_d = CLOSE;
                end
            end
            CLOSE: begin
                gate_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_1Hz) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            gate_q   <= 1'b0;
            full_q   <= 1'b0;
            denied_q <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            gate_q   <= gate_d;
            full_q   <= full_d;
            denied_q <= denied_d;
            empty_q  <= empty_d;
        end
    end

    assign bus.gate_open    = gate_q;
    assign bus.count        = count_q;
    assign bus.full_signal  = full_q;
    assign bus.empty        = empty_q;
    assign bus.entry_denied = denied_q;

`ifdef PARKING_DENY_STATS_EN
    logic [7:0] deny_count_q, deny_count_d;

    always_comb begin
        deny_count_d = deny_count_q;
        if (bus.stats_clr) begin
            deny_count_d = 8'd0;
        end else if (denied_d && (deny_count_q != 8'hff)) begin
            deny_count_d = deny_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (!reset) begin
            deny_count_q <= 8'd0;
        end else begin
            deny_count_q <= deny_count_d;
        end
    end

    assign bus.deny_count = deny_count_q;
`endif

    a_count_in_range: assert property (@(posedge clk_1Hz) disable iff (!reset)
        count_q <= CapCnt);

endmodule
